// File: rtl/ddr2_arb_pkg.sv
// Shared types, widths and helpers for the ddr2_cmd_arbiter slice.
package ddr2_arb_pkg;

  localparam int unsigned ADDR_W       = 25;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned FILL_MAX_DEF = 63;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    SCR  = 3'd1,
    SCW  = 3'd2,
    BLR  = 3'd3,
    BLW  = 3'd4,
    ATR  = 3'd5,
    ATW  = 3'd6,
    NOP7 = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {
    RST_INIT,
    WAIT_RDY,
    IDLE,
    ISSUE,
    BLKWR
  } state_e;

  function automatic logic is_read(cmd_e cmd);
    return (cmd == SCR) || (cmd == BLR);
  endfunction

  function automatic logic is_nop(cmd_e cmd);
    return (cmd == NOP) || (cmd == NOP7);
  endfunction

  // Words in a block transfer: 8*(sz+1), at most 32.
  function automatic logic [5:0] blk_words(logic [1:0] sz);
    return {1'b0, sz, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/ddr2_cmd_arbiter_if.sv
// Requester and controller-side signal bundle for ddr2_cmd_arbiter.
interface ddr2_cmd_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  import ddr2_arb_pkg::*;

  logic [NREQ-1:0]        REQ_VALID;
  logic [3*NREQ-1:0]      REQ_CMD;
  logic [2*NREQ-1:0]      REQ_SZ;
  logic [3*NREQ-1:0]      REQ_OP;
  logic [ADDR_W*NREQ-1:0] REQ_ADDR;
  logic [DATA_W*NREQ-1:0] REQ_DIN;
  logic [NREQ-1:0]        REQ_GRANT;
  logic [NREQ-1:0]        REQ_DREADY;
  logic [2:0]             CMD;
  logic [1:0]             SZ;
  logic [2:0]             OP;
  logic [ADDR_W-1:0]      ADDR;
  logic [DATA_W-1:0]      DIN;
  logic                   INITDDR;
  logic                   NOTFULL;
  logic [6:0]             FILLCOUNT;
  logic                   READY;
  logic                   BUSY;

  modport slave (
    input  REQ_VALID, REQ_CMD, REQ_SZ, REQ_OP, REQ_ADDR, REQ_DIN,
    input  NOTFULL, FILLCOUNT, READY,
    output REQ_GRANT, REQ_DREADY, CMD, SZ, OP, ADDR, DIN, INITDDR, BUSY
  );

  modport master (
    output REQ_VALID, REQ_CMD, REQ_SZ, REQ_OP, REQ_ADDR, REQ_DIN,
    output NOTFULL, FILLCOUNT, READY,
    input  REQ_GRANT, REQ_DREADY, CMD, SZ, OP, ADDR, DIN, INITDDR, BUSY
  );

endinterface

// File: rtl/ddr2_rr_picker.sv
// Combinational round-robin picker: first valid requester after 'last'.
module ddr2_rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] cand;
  int unsigned     c;

  // Scan farthest offset first so the nearest valid requester overwrites.
  always_comb begin
    onehot = '0;
    idx    = '0;
    cand   = '0;
    c      = 0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      c    = (32'(last) + k) % NREQ;
      cand = NREQ'(1) << c;
      if (|(valid & cand)) begin
        onehot = cand;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// Round-robin command/data port scheduler and power-up sequencer in front
// of ddr2_controller; block writes lock the port to one owner.
module ddr2_cmd_arbiter
  import ddr2_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned FILL_MAX = FILL_MAX_DEF
) (
  input logic                CLK,
  input logic                RESET,
  ddr2_cmd_arbiter_if.slave  bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state, state_d;
  logic [IW-1:0]     last, last_d;
  logic [4:0]        beats, beats_d;
  cmd_e              cmd_q, cmd_d;
  logic [1:0]        sz_q, sz_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              init_q, init_d;
  logic [NREQ-1:0]   dready;

  logic [NREQ-1:0]   win_onehot;
  logic [IW-1:0]     win_idx;
  cmd_e              win_cmd;
  logic [1:0]        win_sz;
  logic [2:0]        win_op;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_din;
  logic [DATA_W-1:0] owner_din;
  logic              fill_ok, acc, load;

  ddr2_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .valid  (bus.REQ_VALID),
    .last   (last),
    .onehot (win_onehot),
    .idx    (win_idx)
  );

  always_comb begin
    win_cmd   = NOP;
    win_sz    = '0;
    win_op    = '0;
    win_addr  = '0;
    win_din   = '0;
    owner_din = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_cmd  = cmd_e'(bus.REQ_CMD[3*i +: 3]);
        win_sz   = bus.REQ_SZ[2*i +: 2];
        win_op   = bus.REQ_OP[3*i +: 3];
        win_addr = bus.REQ_ADDR[ADDR_W*i +: ADDR_W];
        win_din  = bus.REQ_DIN[DATA_W*i +: DATA_W];
      end
      if (last == IW'(i)) owner_din = bus.REQ_DIN[DATA_W*i +: DATA_W];
    end
  end

  assign fill_ok = (bus.FILLCOUNT <= 7'(FILL_MAX));
  assign acc     = bus.NOTFULL && (is_read(cmd_q) || fill_ok);

  always_comb begin
    state_d = state;
    last_d  = last;
    beats_d = beats;
    cmd_d   = cmd_q;
    sz_d    = sz_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    grant_d = '0;
    init_d  = 1'b0;
    dready  = '0;
    load    = 1'b0;

    case (state)
      RST_INIT: begin
        init_d  = 1'b1;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: if (bus.READY) state_d = IDLE;
      IDLE:     load = 1'b1;
      ISSUE: begin
        if (acc) begin
          if (cmd_q == BLW) begin
            state_d = BLKWR;
            beats_d = 5'(blk_words(sz_q) - 6'd1);
            cmd_d   = NOP;
            sz_d    = '0;
            op_d    = '0;
            addr_d  = '0;
            din_d   = '0;
          end else begin
            load = 1'b1;
          end
        end
      end
      BLKWR: begin
        if (fill_ok) begin
          dready  = NREQ'(1) << last;
          beats_d = beats - 5'd1;
          if (beats == 5'd1) state_d = IDLE;
        end
      end
      default: state_d = RST_INIT;
    endcase

    // Shared by IDLE and back-to-back issue: a NOP winner consumes its turn
    // but leaves the port idle.
    if (load) begin
      state_d = IDLE;
      cmd_d   = NOP;
      sz_d    = '0;
      op_d    = '0;
      addr_d  = '0;
      din_d   = '0;
      if (|bus.REQ_VALID) begin
        grant_d = win_onehot;
        last_d  = win_idx;
        if (!is_nop(win_cmd)) begin
          state_d = ISSUE;
          cmd_d   = win_cmd;
          sz_d    = win_sz;
          op_d    = win_op;
          addr_d  = win_addr;
          din_d   = win_din;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= RST_INIT;
      last    <= IW'(NREQ - 1);
      beats   <= '0;
      cmd_q   <= NOP;
      sz_q    <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      grant_q <= '0;
      init_q  <= 1'b0;
    end else begin
      state   <= state_d;
      last    <= last_d;
      beats   <= beats_d;
      cmd_q   <= cmd_d;
      sz_q    <= sz_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      grant_q <= grant_d;
      init_q  <= init_d;
    end
  end

  assign bus.CMD        = cmd_q;
  assign bus.SZ         = sz_q;
  assign bus.OP         = op_q;
  assign bus.ADDR       = addr_q;
  assign bus.DIN        = (state == BLKWR) ? owner_din : din_q;
  assign bus.INITDDR    = init_q;
  assign bus.REQ_GRANT  = grant_q;
  assign bus.REQ_DREADY = dready;
  assign bus.BUSY       = (state == ISSUE) || (state == BLKWR);

endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// Directed self-checking bench for ddr2_cmd_arbiter with NREQ=4.
module tb_ddr2_cmd_arbiter;
  import ddr2_arb_pkg::*;

  localparam int unsigned N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  ddr2_cmd_arbiter_if #(.NREQ(N)) bus ();

  ddr2_cmd_arbiter #(.NREQ(N), .FILL_MAX(63)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] c, input logic [1:0] s,
                         input logic [2:0] o, input logic [24:0] a, input logic [15:0] d);
    bus.REQ_VALID[i]        = v;
    bus.REQ_CMD[3*i +: 3]   = c;
    bus.REQ_SZ[2*i +: 2]    = s;
    bus.REQ_OP[3*i +: 3]    = o;
    bus.REQ_ADDR[25*i +: 25] = a;
    bus.REQ_DIN[16*i +: 16] = d;
  endtask

  initial begin
    int pulses, grants_seen, word, beats_seen, stalls, n;
    logic [6:0] fc;

    bus.REQ_VALID = '0;
    bus.REQ_CMD   = '0;
    bus.REQ_SZ    = '0;
    bus.REQ_OP    = '0;
    bus.REQ_ADDR  = '0;
    bus.REQ_DIN   = '0;
    bus.NOTFULL   = 1'b1;
    bus.FILLCOUNT = '0;
    bus.READY     = 1'b0;

    // Reset state and init sequencing
    #12;
    chk("rst_initddr", bus.INITDDR, 0);
    chk("rst_cmd", bus.CMD, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_grant", bus.REQ_GRANT, 0);
    chk("rst_dready", bus.REQ_DREADY, 0);
    rst_n = 1'b1;
    step();
    chk("init_pulse", bus.INITDDR, 1);
    set_req(3, 1, SCR, 0, 0, 25'h33, 16'h0);
    pulses = 0;
    grants_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.INITDDR) pulses++;
      if (|bus.REQ_GRANT) grants_seen++;
    end
    chk("init_once", pulses, 0);
    chk("no_grant_wait", grants_seen, 0);
    bus.READY = 1'b1;
    step();
    chk("rdy_edge_grant", bus.REQ_GRANT, 0);
    step();
    chk("first_grant", bus.REQ_GRANT, 4'b1000);
    chk("first_cmd", bus.CMD, 1);
    chk("first_addr", bus.ADDR, 25'h33);
    chk("busy_issue", bus.BUSY, 1);
    bus.REQ_VALID[3] = 1'b0;
    step();
    chk("idle_cmd", bus.CMD, 0);
    chk("idle_busy", bus.BUSY, 0);

    // Fairness: all four valid, strict rotation back-to-back
    for (int i = 0; i < 4; i++) set_req(i, 1, SCR, 0, 0, 25'h100 + 25'(i), 16'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_grant", bus.REQ_GRANT, 32'(1 << (k % 4)));
      chk("rr_cmd", bus.CMD, 1);
      chk("rr_addr", bus.ADDR, 32'h100 + 32'(k % 4));
    end
    bus.REQ_VALID = '0;
    step();
    chk("rr_end_cmd", bus.CMD, 0);

    // Backpressure: SCW held while NOTFULL=0
    bus.NOTFULL = 1'b0;
    set_req(1, 1, SCW, 0, 0, 25'h1ABCD, 16'hBEEF);
    step();
    chk("bp_grant", bus.REQ_GRANT, 4'b0010);
    chk("bp_cmd0", bus.CMD, 2);
    bus.REQ_VALID[1] = 1'b0;
    set_req(0, 1, SCR, 0, 0, 25'h200, 16'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_cmd", bus.CMD, 2);
      chk("bp_addr", bus.ADDR, 25'h1ABCD);
      chk("bp_din", bus.DIN, 16'hBEEF);
      chk("bp_nogrant", bus.REQ_GRANT, 0);
    end
    bus.NOTFULL = 1'b1;
    step();
    chk("bp_next_grant", bus.REQ_GRANT, 4'b0001);
    chk("bp_next_cmd", bus.CMD, 1);
    chk("bp_next_addr", bus.ADDR, 25'h200);
    bus.REQ_VALID[0] = 1'b0;
    step();
    chk("bp_idle", bus.CMD, 0);

    // Block write from requester 2, SZ=1, FILLCOUNT 60 -> 64 -> 63
    set_req(2, 1, BLW, 1, 0, 25'h55, 16'hD000);
    bus.FILLCOUNT = 7'd60;
    step();
    chk("blk_grant", bus.REQ_GRANT, 4'b0100);
    chk("blk_cmd", bus.CMD, 4);
    chk("blk_sz", bus.SZ, 1);
    chk("blk_hdr_din", bus.DIN, 16'hD000);
    bus.REQ_VALID[2] = 1'b0;
    bus.REQ_DIN[47:32] = 16'hD001;
    set_req(0, 1, SCR, 0, 0, 25'h300, 16'h0);
    set_req(1, 1, SCR, 0, 0, 25'h301, 16'h0);
    set_req(3, 1, SCR, 0, 0, 25'h303, 16'h0);
    step();
    chk("blk_cmd_cleared", bus.CMD, 0);
    chk("blk_addr_cleared", bus.ADDR, 0);
    word = 1;
    beats_seen = 0;
    stalls = 0;
    for (int cyc = 0; cyc < 40 && beats_seen < 15; cyc++) begin
      fc = (beats_seen < 5) ? 7'd60 : (stalls < 3) ? 7'd64 : 7'd63;
      bus.FILLCOUNT = fc;
      bus.REQ_DIN[47:32] = 16'hD000 + 16'(word);
      #1;
      chk("blk_dready", bus.REQ_DREADY, (fc <= 7'd63) ? 32'h4 : 32'h0);
      chk("blk_din", bus.DIN, 32'hD000 + 32'(word));
      chk("blk_nogrant", bus.REQ_GRANT, 0);
      chk("blk_busy", bus.BUSY, 1);
      step();
      if (fc <= 7'd63) begin
        beats_seen++;
        word++;
      end else begin
        stalls++;
      end
    end
    chk("blk_done_busy", bus.BUSY, 0);
    chk("blk_done_dready", bus.REQ_DREADY, 0);
    chk("blk_done_grant", bus.REQ_GRANT, 0);
    bus.FILLCOUNT = '0;
    step();
    chk("post_blk_g3", bus.REQ_GRANT, 4'b1000);
    bus.REQ_VALID[3] = 1'b0;
    step();
    chk("post_blk_g0", bus.REQ_GRANT, 4'b0001);
    bus.REQ_VALID[0] = 1'b0;
    step();
    chk("post_blk_g1", bus.REQ_GRANT, 4'b0010);
    bus.REQ_VALID[1] = 1'b0;
    step();
    chk("post_blk_idle", bus.CMD, 0);

    // NOP granted but never issued, then ATW gated by NOTFULL and FILLCOUNT
    set_req(1, 1, NOP, 0, 0, 25'h9, 16'h0);
    step();
    chk("nop_grant", bus.REQ_GRANT, 4'b0010);
    chk("nop_cmd", bus.CMD, 0);
    chk("nop_busy", bus.BUSY, 0);
    bus.REQ_VALID[1] = 1'b0;
    set_req(3, 1, ATW, 0, 5, 25'h777, 16'h1234);
    bus.FILLCOUNT = 7'd64;
    step();
    chk("atw_grant", bus.REQ_GRANT, 4'b1000);
    chk("atw_cmd", bus.CMD, 6);
    chk("atw_op", bus.OP, 5);
    chk("atw_addr", bus.ADDR, 25'h777);
    chk("atw_din", bus.DIN, 16'h1234);
    bus.REQ_VALID[3] = 1'b0;
    step();
    chk("atw_hold_fill", bus.CMD, 6);
    chk("atw_hold_nogrant", bus.REQ_GRANT, 0);
    bus.NOTFULL = 1'b0;
    bus.FILLCOUNT = 7'd63;
    step();
    chk("atw_hold_nf", bus.CMD, 6);
    bus.NOTFULL = 1'b1;
    step();
    chk("atw_taken", bus.CMD, 0);
    chk("atw_idle_busy", bus.BUSY, 0);
    bus.FILLCOUNT = '0;

    // Largest block (SZ=3): 31 beats after the header
    set_req(0, 1, BLW, 3, 0, 25'h40, 16'hA000);
    step();
    chk("sz3_grant", bus.REQ_GRANT, 4'b0001);
    chk("sz3_sz", bus.SZ, 3);
    bus.REQ_VALID[0] = 1'b0;
    step();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (!bus.BUSY) break;
      if (bus.REQ_DREADY[0]) n++;
      step();
    end
    chk("sz3_beats", n, 31);

    // Reset in the middle of a block write
    set_req(1, 1, BLW, 0, 0, 25'h60, 16'hC000);
    step();
    chk("rb_grant", bus.REQ_GRANT, 4'b0010);
    bus.REQ_VALID[1] = 1'b0;
    step();
    for (int i = 0; i < 4; i++) step();
    chk("rb_pre_dready", bus.REQ_DREADY, 4'b0010);
    chk("rb_pre_din", bus.DIN, 16'hC000);
    bus.READY = 1'b0;
    set_req(2, 1, SCR, 0, 0, 25'h222, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_busy", bus.BUSY, 0);
    chk("rb_dready", bus.REQ_DREADY, 0);
    chk("rb_din", bus.DIN, 0);
    chk("rb_cmd", bus.CMD, 0);
    chk("rb_grant0", bus.REQ_GRANT, 0);
    chk("rb_initddr0", bus.INITDDR, 0);
    step();
    chk("rb_held_initddr", bus.INITDDR, 0);
    rst_n = 1'b1;
    step();
    chk("rb_init_pulse", bus.INITDDR, 1);
    step();
    chk("rb_init_end", bus.INITDDR, 0);
    chk("rb_wait_grant", bus.REQ_GRANT, 0);
    step();
    chk("rb_wait_grant2", bus.REQ_GRANT, 0);
    bus.READY = 1'b1;
    step();
    chk("rb_idle_grant", bus.REQ_GRANT, 0);
    step();
    chk("rb_first_grant", bus.REQ_GRANT, 4'b0100);
    chk("rb_first_addr", bus.ADDR, 25'h222);
    bus.REQ_VALID[2] = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr2_cmd_arbiter.md
# ddr2_cmd_arbiter

Front-end scheduler for `ddr2_controller`: shares its single command/data port between `NREQ` requesters with round-robin arbitration, and sequences the controller's power-up (`INITDDR` pulse, then wait for `READY`). It enforces the controller's acceptance rules: command-FIFO space via `NOTFULL`, and data-FIFO space via `FILLCOUNT <= 63`. Block writes hold the port locked to one owner until all `8*(SZ+1)` data words are delivered. It sits between the requesting client logic and `ddr2_controller`.

## Interface

Parameters:
- `NREQ`, default 4: number of requesters; minimum 2.
- `FILL_MAX`, default 63: highest `FILLCOUNT` value at which a data word may be presented.

Ports (clock and reset first):
- `CLK`  in  1  single clock.
- `RESET`  in  1  asynchronous, active-low reset.
- `REQ_VALID`  in  NREQ  requester i holds a command.
- `REQ_CMD`  in  3*NREQ  command code per requester.
- `REQ_SZ`  in  2*NREQ  block size per requester.
- `REQ_OP`  in  3*NREQ  atomic op per requester.
- `REQ_ADDR`  in  25*NREQ  address per requester.
- `REQ_DIN`  in  16*NREQ  write data per requester; also carries block-write beats.
- `REQ_GRANT`  out  NREQ  one-cycle pulse: command of requester i loaded.
- `REQ_DREADY`  out  NREQ  block-write beat of requester i taken this edge.
- `CMD`, `SZ`, `OP`, `ADDR`, `DIN`  out  3/2/3/25/16  to the controller.
- `INITDDR`  out  1  init pulse to the controller.
- `NOTFULL`  in  1  controller command-FIFO space.
- `FILLCOUNT`  in  7  controller data-FIFO fill level.
- `READY`  in  1  controller initialized.
- `BUSY`  out  1  a command is held or a block write is in progress.

## Operation

- Command codes: 0/7 NOP, 1 SCR, 2 SCW, 3 BLR, 4 BLW, 5 ATR, 6 ATW.
- Acceptance condition `acc`, evaluated on the command currently held on `CMD`:
  - reads (1, 3): `NOTFULL`;
  - writes/atomics (2, 4, 5, 6): `NOTFULL && FILLCOUNT <= FILL_MAX`.
- FSM states:
  - `RST_INIT`: entered on reset. `INITDDR`=1 for exactly one cycle on the first edge after reset release.
  - `WAIT_RDY`: no grants. Leaves to `IDLE` on the edge where `READY`=1.
  - `IDLE`: `CMD`=0, `BUSY`=0. Picks the round-robin winner among `REQ_VALID`, starting from `last+1` mod NREQ.
    - Winner fields are registered onto the outputs, with `REQ_GRANT[i]`=1 on the same edge. Go to `ISSUE`.
    - A winner whose command is NOP is granted without being issued: it updates `last`, the state stays `IDLE`, and `CMD` stays 0.
  - `ISSUE`: outputs held stable until an edge with `acc`=1.
    - On that edge, if `CMD`=4 go to `BLKWR` with `beats = 8*(SZ+1) - 1`. The header carries the first data word.
    - Otherwise either load the next winner back-to-back (grant pulse on the same edge) or return to `IDLE`.
  - `BLKWR`: `CMD`=0, `ADDR`/`SZ`/`OP`=0, `DIN` = owner's `REQ_DIN`.
    - When `FILLCOUNT <= FILL_MAX`: `REQ_DREADY[owner]`=1 and `beats` decrements.
    - When the data FIFO is full: beat stalled, `DREADY`=0, `DIN` held.
    - The owner must present valid data on every edge where `DREADY`=1; there is no data-valid input.
    - Leaves to `IDLE` on the edge where `beats` goes 1→0. No other requester is granted while in `BLKWR`.
- `BUSY` = state ∈ {`ISSUE`, `BLKWR`}.
- Requester fields must stay stable from the rise of `REQ_VALID` until its `REQ_GRANT`; the requester drops `REQ_VALID` or changes its fields after the grant edge.

## Timing

- Reset (async, any state): every output is 0, state = `RST_INIT`, `last` = NREQ-1, `beats` = 0.
  - Reset during `BLKWR` abandons the burst. The controller is re-initialized through a fresh `INITDDR` pulse.
- Grant latency: `REQ_VALID` sampled at edge n → `CMD` valid and `REQ_GRANT` high after edge n. Minimum one held-command cycle per non-NOP command.
- Peak rate: one command per cycle while `acc`=1 and requesters are pending.
- Block write of size SZ occupies at least `1 + 8*(SZ+1) - 1` cycles: header plus beats, longer when the data FIFO is full.
- Boundaries:
  - `FILLCOUNT` = 63 still accepts data; 64 stalls.
  - `NOTFULL` drop while a command is held: the command stays held, no loss or duplication.
  - All requesters valid: strict rotation 0,1,2,3,0…
  - `SZ` = 3: `beats` = 31, so `beats` is 5 bits wide.

## Structure

- Package `ddr2_arb_pkg` holds:
  - the command enum (NOP, SCR, SCW, BLR, BLW, ATR, ATW, NOP7);
  - the FSM state enum;
  - `ADDR_W`=25, `DATA_W`=16, `FILL_MAX_DEF`=63;
  - function `is_read(cmd)` and function `blk_words(sz)`.
- Sub-module `ddr2_rr_picker`: combinational round-robin priority encoder. Inputs are the `REQ_VALID` vector and `last`; outputs are the one-hot winner and its index.

## Test plan

- Init sequencing: release `RESET`, hold `READY`=0 for 20 cycles, then raise it → exactly one `INITDDR` pulse; no grants before `READY`; first grant on the edge after `READY`.
- Fairness: all 4 requesters issue SCR continuously with `NOTFULL`=1 → grants 0,1,2,3,0,1,2,3; `CMD`=1 on consecutive cycles.
- Backpressure: SCW held, `NOTFULL`=0 for 5 cycles → `CMD`/`ADDR`/`DIN` stable for those 5 cycles; consumed on the first edge with `NOTFULL`=1; no second grant meanwhile.
- Block write: requester 2 issues BLW with `SZ`=1 and `FILLCOUNT` swept 60→64→63 → 15 `DREADY` beats; beat stalls while `FILLCOUNT`=64; requesters 0/1/3 get no grant until the burst ends.
- NOP and mixed traffic: requester 1 sends NOP, requester 3 sends ATW (`OP`=5) → NOP granted with `CMD` staying 0; then ATW issued with `OP`=5 and waits for both `NOTFULL` and `FILLCOUNT <= 63`.
- Reset during `BLKWR` at beat 4 → all outputs 0 immediately; after release a fresh `INITDDR` pulse and `WAIT_RDY` are entered.
